seq_add16_ctrl: RTL
===================

SEQ_ADD16_CTRL -- requirements
Module: seq_add16_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: total operand width in bits. SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4: bits added per clock cycle by the single internal slice adder.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 start  input  1  request to begin one operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 cin  input  1  carry-in for add; sampled with start; ignored when sub=1.
REQ-010 busy  output  1  high while slices are being processed (RUN state).
REQ-011 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-012 sum  output  WIDTH  registered result of the last completed operation.
REQ-013 cout  output  1  registered carry-out of the last completed operation (for sub, 1 = no borrow).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL:
- capture a into opA;
- capture b into opB, or ~b when sub=1;
- load the carry register with cin, or with 1 when sub=1;
- clear the slice index to 0;
- move to RUN.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE with no register changes.
REQ-017 Each RUN edge SHALL:
- add slice [idx*SLICE +: SLICE] of opA and opB plus the carry register, as one (SLICE+1)-bit sum;
- write the low SLICE bits into the same slice of the internal result register;
- store the MSB into the carry register;
- increment idx.
REQ-018 The RUN edge that processes slice WIDTH/SLICE-1 SHALL:
- copy the full result register to sum and the final carry to cout;
- move to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return unconditionally to IDLE.
REQ-020 Latency: if start is sampled at edge k, done SHALL be high for exactly the cycle between edges k+WIDTH/SLICE and k+WIDTH/SLICE+1 (4 and 5 for the defaults).
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both are decoded from the state register.
REQ-022 start asserted in RUN or DONE SHALL be ignored and not queued. The minimum start-to-start spacing is WIDTH/SLICE+2 cycles.
REQ-023 a, b, sub and cin SHALL be ignored outside the start-sampling edge; changing them during RUN SHALL NOT affect the result.
REQ-024 sum and cout SHALL change only on the RUN-to-DONE edge and SHALL hold between operations. No partial result SHALL appear on sum during RUN.
REQ-025 Arithmetic is modulo 2^WIDTH. cout SHALL equal bit WIDTH of a + b + cin (add) or of a + ~b + 1 (sub).

Reset
REQ-026 While rst=1, the block SHALL immediately force:
- state to IDLE;
- idx and the carry register to 0;
- opA, opB and the internal result register to 0;
- sum to 0 and cout to 0;
- busy to 0 and done to 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse. After release, the block SHALL accept a new start on the first edge.

Verification
REQ-028 a=0x1234, b=0x0FFF, cin=0, sub=0, start for one cycle -> busy for 4 cycles, then done=1 for one cycle with sum=0x2233, cout=0.
REQ-029 a=0xFFFF, b=0x0001, cin=0, sub=0 -> carry ripples through all 4 slices: sum=0x0000, cout=1.
REQ-030 a=0x0005, b=0x0007, cin=1, sub=1 -> cin ignored: sum=0xFFFE, cout=0; then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-031 Start an op with a=0x0000, b=0x0000, cin=1; two cycles later assert start with a=0xAAAA and change a/b -> second start ignored; a single done with sum=0x0001, cout=0.
REQ-032 Complete one op with sum=0x2233, then start another; assert rst during the second RUN cycle -> sum=0, cout=0, busy=0 at once, no done pulse; a start right after rst release completes normally.

Source files
------------

// File: rtl/seq_add16_ctrl.sv
// ---------------------------------------------------------------------------
// seq_add16_ctrl
//   Multi-cycle adder/subtractor. One SLICE-bit adder is reused once per
//   clock to process a WIDTH-bit operation, least-significant slice first.
//   Subtraction is done as a + ~b + 1, so cout = 1 means "no borrow".
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   begin an operation (sampled only in IDLE)
//   sub    in   0 = a + b + cin, 1 = a - b (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   cin    in   carry-in for add (sampled with start, ignored for sub)
//   busy   out  high while slices are being processed (RUN)
//   done   out  one-cycle pulse when sum/cout hold a new result (DONE)
//   sum    out  registered result of the last completed operation
//   cout   out  registered carry-out of the last completed operation
// ---------------------------------------------------------------------------
module seq_add16_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("seq_add16_ctrl: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   op_a_q,  op_a_d;
  logic [WIDTH-1:0]   op_b_q,  op_b_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic [SLICE:0]     slice_sum;

  // The one shared slice adder: current slice of both operands plus carry.
  always_comb begin
    slice_sum = {1'b0, op_a_q[idx_q*SLICE +: SLICE]}
              + {1'b0, op_b_q[idx_q*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry_q};
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          // Subtract is a + ~b + 1: invert b now and seed the carry with 1.
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d[idx_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        carry_d = slice_sum[SLICE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // res_d already contains the final slice written just above, so
          // sum is published complete and never shows partial results.
          sum_d   = res_d;
          cout_d  = slice_sum[SLICE];
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  // Operand and result registers are reset too because the reset state of
  // sum/cout and the internal registers is part of the defined behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
